// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: steps a shared-memory, single-ALU datapath
// through fetch/decode/execute/memory/writeback for one instruction at a time.
// Latency: 3 to 5 cycles per instruction when memory answers at once. Each
//   cycle with mem_ready low in FETCH, MEMRD or MEMWR adds one cycle.
// Backpressure: holds mem_req, and its address and strobe selects, stable
//   until mem_ready arrives.
//
// Optional feature: define MC_PERF_CNT_EN to build the cyc/instr/stall
// performance counters. When it is undefined, the counter ports read 0 and
// no counter flops are built.
//
// Ports:
//   clk, reset (synchronous, active-high)
//   op         IR[31:26]; stable from DECODE until the next FETCH
//   zero       ALU zero flag, used for beq/bne
//   mem_ready  the unified memory completes the current access this cycle
//   mem_req/memwrite/iord      memory request, write strobe, address select
//   irwrite/pcen               IR load and PC enable
//   regwrite/regdst/memtoreg   register-file write controls
//   alusrca/alusrcb/zeroext/pcsrc/aluop   datapath mux and ALU controls
//   illegal_op                 one-cycle pulse in DECODE for an unsupported op
//   cyc_cnt/instr_cnt/stall_cnt   performance counters (CNT_W bits)
module mc_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             memwrite,
  output logic             iord,
  output logic             irwrite,
  output logic             pcen,
  output logic             regwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic             zeroext,
  output logic [1:0]       pcsrc,
  output logic [2:0]       aluop,
  output logic             illegal_op,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_IMMEX,
    S_IMMWB,
    S_JUMP
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    zeroext    = 1'b0;
    pcsrc      = 2'b00;
    aluop      = 3'b000;
    illegal_op = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      // PC+4 is computed while the instruction is read. The IR and PC are
      // only updated in the cycle that memory returns the data.
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcen    = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end
      end

      // The ALU speculatively computes the branch target (PC + imm<<2) into
      // ALUOut so that BRANCH can use it without another add.
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW:            state_d = S_MEMADR;
          OP_RTYPE:                state_d = S_EXEC;
          OP_BEQ, OP_BNE:          state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMMEX;
          OP_J:                    state_d = S_JUMP;
          default: begin
            // Unsupported opcode: flag it and skip to the next instruction
            // without touching any architectural state.
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end
      end

      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end

      // The write strobe stays up for the whole access, including stalls.
      S_MEMWR: begin
        mem_req  = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end
      end

      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 3'b010;
        state_d = S_ALUWB;
      end

      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = S_FETCH;
      end

      // The ALU subtracts A-B for the zero flag. The PC is loaded from the
      // target that DECODE left in ALUOut.
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 3'b001;
        pcsrc   = 2'b01;
        pcen    = (op == OP_BNE) ? ~zero : zero;
        state_d = S_FETCH;
      end

      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (op)
          OP_ANDI: begin
            aluop   = 3'b011;
            zeroext = 1'b1;
          end
          OP_ORI: begin
            aluop   = 3'b100;
            zeroext = 1'b1;
          end
          default: aluop = 3'b000;
        endcase
        state_d = S_IMMWB;
      end

      S_IMMWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_JUMP: begin
        pcsrc   = 2'b10;
        pcen    = 1'b1;
        state_d = S_FETCH;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Reset takes effect on the outputs in the same cycle it is raised, so
    // an in-flight memory access is abandoned without waiting for the edge.
    if (reset) begin
      state_d    = S_IDLE;
      mem_req    = 1'b0;
      memwrite   = 1'b0;
      iord       = 1'b0;
      irwrite    = 1'b0;
      pcen       = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      zeroext    = 1'b0;
      pcsrc      = 2'b00;
      aluop      = 3'b000;
      illegal_op = 1'b0;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, instr_q, stall_q;
  logic             stall_cyc;

  // A stall is any cycle spent waiting on memory.
  assign stall_cyc = ((state_q == S_FETCH) || (state_q == S_MEMRD) ||
                      (state_q == S_MEMWR)) && !mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q   <= '0;
      instr_q <= '0;
      stall_q <= '0;
    end else begin
      cyc_q <= cyc_q + CNT_W'(1);
      // Counted on the edge that enters DECODE, so the new count is already
      // visible during the DECODE cycle.
      if (state_d == S_DECODE) begin
        instr_q <= instr_q + CNT_W'(1);
      end
      if (stall_cyc) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  assign cyc_cnt   = cyc_q;
  assign instr_cnt = instr_q;
  assign stall_cnt = stall_q;
`else
  assign cyc_cnt   = '0;
  assign instr_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: builds a per-cycle stimulus/expectation script from
// instruction-level rules, replays it and compares every cycle.
module tb_mc_controller;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcen;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic       illegal_op;
  } ov_t;

  typedef struct packed {
    logic       rst;
    logic       mr;
    logic       z;
    logic [5:0] op;
  } stim_t;

  typedef struct packed {
    ov_t         ov;
    logic [31:0] cyc;
    logic [31:0] ins;
    logic [31:0] stl;
  } exp_t;

  logic        clk, reset, zero, mem_ready;
  logic [5:0]  op;
  logic        mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg;
  logic        alusrca, zeroext, illegal_op;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  aluop;
  logic [31:0] cyc_cnt, instr_cnt, stall_cnt;

  mc_controller #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .pcen(pcen), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .zeroext(zeroext), .pcsrc(pcsrc),
    .aluop(aluop), .illegal_op(illegal_op),
    .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  stim_t sq[$];
  exp_t  eq[$];
  int    cyc_run, ins_run, stl_run;
  int    checks, errors, n_illegal, ill_seen;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit legal(input logic [5:0] o);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_BEQ) ||
           (o == OP_BNE) || (o == OP_ADDI) || (o == OP_ANDI) || (o == OP_ORI) ||
           (o == OP_J);
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Append one cycle to the script. The counters in each entry are the
  // values that must be visible during that cycle.
  task automatic push(input logic rst, input logic mr, input logic z,
                      input logic [5:0] o, input ov_t v,
                      input bit is_dec, input bit is_stall);
    stim_t s;
    exp_t  e;
    if (is_dec) ins_run++;
    s.rst = rst; s.mr = mr; s.z = z; s.op = o;
    e.ov = v; e.cyc = cyc_run; e.ins = ins_run; e.stl = stl_run;
    sq.push_back(s);
    eq.push_back(e);
    if (rst) begin
      cyc_run = 0; ins_run = 0; stl_run = 0;
    end else begin
      cyc_run++;
      if (is_stall) stl_run++;
    end
  endtask

  // n reset cycles (all outputs low), then the single IDLE cycle.
  task automatic do_reset(input int n);
    repeat (n) push(1'b1, rb(), rb(), 6'($urandom), '0, 0, 0);
    push(1'b0, rb(), rb(), 6'($urandom), '0, 0, 0);
  endtask

  task automatic fetch_decode(input logic [5:0] o, input int fst);
    ov_t v;
    v = '0; v.mem_req = 1'b1; v.alusrcb = 2'b01;
    repeat (fst) push(1'b0, 1'b0, rb(), o, v, 0, 1);
    v.irwrite = 1'b1; v.pcen = 1'b1;
    push(1'b0, 1'b1, rb(), o, v, 0, 0);
    v = '0; v.alusrcb = 2'b11; v.illegal_op = !legal(o);
    push(1'b0, rb(), rb(), o, v, 1, 0);
  endtask

  // One full instruction. fst/mst are the wait cycles before memory answers
  // the fetch and the data access. zsel < 0 picks the zero flag at random.
  task automatic issue(input logic [5:0] o, input int fst, input int mst, input int zsel);
    ov_t  v;
    logic zz;
    if (!legal(o)) n_illegal++;
    fetch_decode(o, fst);
    v = '0;
    if (o == OP_LW || o == OP_SW) begin
      v.alusrca = 1'b1; v.alusrcb = 2'b10;
      push(1'b0, rb(), rb(), o, v, 0, 0);
      v = '0; v.mem_req = 1'b1; v.iord = 1'b1; v.memwrite = (o == OP_SW);
      repeat (mst) push(1'b0, 1'b0, rb(), o, v, 0, 1);
      push(1'b0, 1'b1, rb(), o, v, 0, 0);
      if (o == OP_LW) begin
        v = '0; v.regwrite = 1'b1; v.memtoreg = 1'b1;
        push(1'b0, rb(), rb(), o, v, 0, 0);
      end
    end else if (o == OP_R) begin
      v.alusrca = 1'b1; v.aluop = 3'b010;
      push(1'b0, rb(), rb(), o, v, 0, 0);
      v = '0; v.regwrite = 1'b1; v.regdst = 1'b1;
      push(1'b0, rb(), rb(), o, v, 0, 0);
    end else if (o == OP_BEQ || o == OP_BNE) begin
      zz = (zsel < 0) ? rb() : 1'(zsel);
      v.alusrca = 1'b1; v.aluop = 3'b001; v.pcsrc = 2'b01;
      v.pcen = (o == OP_BEQ) ? zz : ~zz;
      push(1'b0, rb(), zz, o, v, 0, 0);
    end else if (o == OP_ADDI || o == OP_ANDI || o == OP_ORI) begin
      v.alusrca = 1'b1; v.alusrcb = 2'b10;
      v.aluop   = (o == OP_ANDI) ? 3'b011 : (o == OP_ORI) ? 3'b100 : 3'b000;
      v.zeroext = (o != OP_ADDI);
      push(1'b0, rb(), rb(), o, v, 0, 0);
      v = '0; v.regwrite = 1'b1;
      push(1'b0, rb(), rb(), o, v, 0, 0);
    end else if (o == OP_J) begin
      v.pcsrc = 2'b10; v.pcen = 1'b1;
      push(1'b0, rb(), rb(), o, v, 0, 0);
    end
  endtask

  int          b, n, s0, idx, sel;
  logic [5:0]  ro;
  ov_t         got;
  logic [95:0] wc;

  initial begin
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; op = '0;
    cyc_run = 0; ins_run = 0; stl_run = 0;
    checks = 0; errors = 0; n_illegal = 0; ill_seen = 0;

    // Reset for 3 cycles, then lw with memory always ready.
    do_reset(3);
    chk("reset_plus_idle_len", eq.size(), 4);
    b = eq.size();
    issue(OP_LW, 0, 0, -1);
    chk("lw_len", eq.size() - b, 5);
    n = 0;
    for (int k = b; k < eq.size(); k++) n += int'(eq[k].ov.regwrite & eq[k].ov.memtoreg);
    chk("lw_wb_cycles", n, 1);
    chk("lw_wb_last", int'(eq[eq.size()-1].ov.regwrite & eq[eq.size()-1].ov.memtoreg), 1);

    // sw with two wait cycles in MEMWR.
    b = eq.size(); s0 = stl_run;
    issue(OP_SW, 0, 2, -1);
    chk("sw_len", eq.size() - b, 6);
    chk("sw_stalls", stl_run - s0, 2);
    n = 0;
    for (int k = b; k < eq.size(); k++) n += int'(eq[k].ov.memwrite & eq[k].ov.mem_req);
    chk("sw_strobe_cycles", n, 3);

    // Branches.
    issue(OP_BEQ, 0, 0, 1);
    chk("beq_z1_pcen", int'(eq[eq.size()-1].ov.pcen), 1);
    chk("beq_pcsrc", int'(eq[eq.size()-1].ov.pcsrc), 1);
    issue(OP_BNE, 0, 0, 1);
    chk("bne_z1_pcen", int'(eq[eq.size()-1].ov.pcen), 0);
    issue(OP_BNE, 1, 0, 0);
    chk("bne_z0_pcen", int'(eq[eq.size()-1].ov.pcen), 1);

    // ori.
    issue(OP_ORI, 0, 0, -1);
    chk("ori_aluop", int'(eq[eq.size()-2].ov.aluop), 4);
    chk("ori_zeroext", int'(eq[eq.size()-2].ov.zeroext), 1);
    chk("ori_alusrcb", int'(eq[eq.size()-2].ov.alusrcb), 2);
    chk("ori_wb", int'({eq[eq.size()-1].ov.regwrite, eq[eq.size()-1].ov.regdst}), 2);

    // Unsupported opcode.
    b = eq.size();
    issue(6'b111111, 0, 0, -1);
    chk("illegal_len", eq.size() - b, 2);
    chk("illegal_pulse", int'(eq[eq.size()-1].ov.illegal_op), 1);
    chk("illegal_no_side", int'({eq[eq.size()-1].ov.regwrite, eq[eq.size()-1].ov.memwrite,
                                 eq[eq.size()-1].ov.pcen}), 0);

    // Reset while MEMRD is still waiting on memory.
    fetch_decode(OP_LW, 0);
    got = '0; got.alusrca = 1'b1; got.alusrcb = 2'b10;
    push(1'b0, rb(), rb(), OP_LW, got, 0, 0);
    push(1'b1, 1'b0, rb(), OP_LW, '0, 0, 0);
    push(1'b0, rb(), rb(), OP_LW, '0, 0, 0);
    idx = eq.size() - 1;
    chk("rst_memrd_idle_cnt", int'(eq[idx].cyc + eq[idx].ins + eq[idx].stl), 0);

    // Random instruction mix with random memory wait states.
    repeat (150) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: ro = OP_LW;   1: ro = OP_SW;   2: ro = OP_R;    3: ro = OP_BEQ;
        4: ro = OP_BNE;  5: ro = OP_ADDI; 6: ro = OP_ANDI; 7: ro = OP_ORI;
        8: ro = OP_J;    default: ro = 6'($urandom);
      endcase
      issue(ro, $urandom_range(0, 2), $urandom_range(0, 3), -1);
      if ($urandom_range(0, 29) == 0) do_reset($urandom_range(1, 2));
    end

    // Replay the script: drive just after the rising edge, compare at the
    // falling edge.
    for (int i = 0; i < sq.size(); i++) begin
      @(posedge clk);
      #1;
      reset = sq[i].rst; mem_ready = sq[i].mr; zero = sq[i].z; op = sq[i].op;
      @(negedge clk);
      got.mem_req = mem_req;   got.memwrite = memwrite; got.iord = iord;
      got.irwrite = irwrite;   got.pcen = pcen;         got.regwrite = regwrite;
      got.regdst = regdst;     got.memtoreg = memtoreg; got.alusrca = alusrca;
      got.alusrcb = alusrcb;   got.zeroext = zeroext;   got.pcsrc = pcsrc;
      got.aluop = aluop;       got.illegal_op = illegal_op;
      checks++;
      if (got !== eq[i].ov) begin
        errors++;
        $display("FAIL outputs cycle %0d: got %h want %h", i, got, eq[i].ov);
      end
`ifdef MC_PERF_CNT_EN
      wc = {eq[i].cyc, eq[i].ins, eq[i].stl};
`else
      wc = '0;
`endif
      checks++;
      if ({cyc_cnt, instr_cnt, stall_cnt} !== wc) begin
        errors++;
        $display("FAIL counters cycle %0d: got cyc %0d instr %0d stall %0d want %h",
                 i, cyc_cnt, instr_cnt, stall_cnt, wc);
      end
      if (illegal_op === 1'b1) ill_seen++;
    end

    chk("illegal_pulse_total", ill_seen, n_illegal);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
